// File: rtl/hazard_unit_mc.sv
// Hazard unit for the five-stage MIPS pipeline: forwarding, load-use and branch stalls,
// a multi-cycle execute FSM and a saturating stall-cycle counter.
module hazard_unit_mc #(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0] RtE,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic [REG_AW-1:0] WriteRegW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              MemtoRegM,
  input  logic              BranchD,
  input  logic              JumpD,
  input  logic              PCSrcTakenD,
  input  logic              StartE,
  input  logic              ClrCount,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              BusyE,
  output logic              DoneE,
  output logic [CNT_W-1:0]  StallCount
);
  localparam int DW = $clog2(MC_LAT);
  localparam logic [DW-1:0] DCNT_INIT = DW'(MC_LAT - 2);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [DW-1:0]    r_dcnt, w_dcnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_mcstall, w_lwstall, w_brstall, w_hazstall;

  // Register 0 is hard-wired to zero, so it can never create a dependency.
  function automatic logic f_hit(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && f_hit(RsE, WriteRegM))      ForwardAE = 2'b10;
    else if (RegWriteW && f_hit(RsE, WriteRegW)) ForwardAE = 2'b01;
    ForwardBE = 2'b00;
    if (RegWriteM && f_hit(RtE, WriteRegM))      ForwardBE = 2'b10;
    else if (RegWriteW && f_hit(RtE, WriteRegW)) ForwardBE = 2'b01;
    ForwardAD = RegWriteM && f_hit(RsD, WriteRegM);
    ForwardBD = RegWriteM && f_hit(RtD, WriteRegM);
  end

  assign w_lwstall  = MemtoRegE && (f_hit(RtE, RsD) || f_hit(RtE, RtD));
  assign w_brstall  = BranchD &&
                      ((RegWriteE && (f_hit(WriteRegE, RsD) || f_hit(WriteRegE, RtD))) ||
                       (MemtoRegM && (f_hit(WriteRegM, RsD) || f_hit(WriteRegM, RtD))));
  assign w_hazstall = w_lwstall || w_brstall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_dcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dcnt  <= w_dcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    case (r_state)
      S_IDLE: if (StartE) begin
        w_state_nxt = S_BUSY;
        w_dcnt_nxt  = DCNT_INIT;
      end
      S_BUSY: if (r_dcnt != '0) w_dcnt_nxt = r_dcnt - DW'(1);
              else              w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The multi-cycle stall overrides the ordinary hazards and bubbles E/M instead of D/E.
  always_comb begin
    w_mcstall = 1'b0;
    BusyE     = 1'b0;
    DoneE     = 1'b0;
    case (r_state)
      S_IDLE: w_mcstall = reset && StartE;
      S_BUSY: begin
        BusyE     = 1'b1;
        w_mcstall = (r_dcnt != '0);
        DoneE     = (r_dcnt == '0);
      end
      default: ;
    endcase
    StallF = w_mcstall || w_hazstall;
    StallD = StallF;
    StallE = w_mcstall;
    FlushE = !w_mcstall && w_hazstall;
    FlushM = w_mcstall;
    FlushD = (PCSrcTakenD || JumpD) && !StallD;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          r_stall_cnt <= '0;
    else if (ClrCount)                   r_stall_cnt <= '0;
    else if (StallF && ~&r_stall_cnt)    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

  assign StallCount = r_stall_cnt;
endmodule
